regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite/writeReg/writeData) between three writeback requesters: 0 = ALU, 1 = load unit, 2 = multiplier.
- Each requester uses a valid/ready handshake. One request is granted per cycle.
- The granted write is registered and presented to the register file one cycle later.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 tb/tb_regfile_wb_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU (0), load unit (1) and multiplier (2)
// Arbitration: fixed priority 0 > 1 > 2 by default; round-robin when the WB_RR_EN macro is defined.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          req_valid,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_data,
   output logic [2:0]          req_ready,
   output logic                RegWrite,
   output logic [ADDR_W-1:0]   writeReg,
   output logic [DATA_W-1:0]   writeData,
   output logic [CNT_W-1:0]    commit_count
);
   logic [1:0]        grantIdx;
   logic              grantValid;
   logic [ADDR_W-1:0] grantAddr;
   logic [DATA_W-1:0] grantData;
   logic              commitNext;
`ifdef WB_RR_EN
   logic [1:0] lastGrant;
   logic [1:0] firstIdx;
   logic [1:0] secondIdx;
   logic [1:0] thirdIdx;
   // Search order rotates so the requester after the last winner is tried first
   always_comb begin
      firstIdx  = (lastGrant >= 2'd2) ? 2'd0 : lastGrant + 2'd1;
      secondIdx = (firstIdx == 2'd2) ? 2'd0 : firstIdx + 2'd1;
      thirdIdx  = (secondIdx == 2'd2) ? 2'd0 : secondIdx + 2'd1;
      grantIdx  = req_valid[firstIdx] ? firstIdx : req_valid[secondIdx] ? secondIdx : thirdIdx;
   end
   // Remember the winner of each transfer; reset points at 2 so requester 0 leads
   always_ff @(posedge clk) begin
      if (reset)
         lastGrant <= 2'd2;
      else if (grantValid)
         lastGrant <= grantIdx;
   end
`else
   // Fixed priority: lowest index wins
   always_comb grantIdx = req_valid[0] ? 2'd0 : req_valid[1] ? 2'd1 : 2'd2;
`endif
   // One-hot grant, suppressed during reset so requesters keep their requests
   always_comb begin
      grantValid = (|req_valid) && !reset;
      req_ready  = grantValid ? (3'b001 << grantIdx) : 3'b000;
      grantAddr  = req_addr[grantIdx*ADDR_W +: ADDR_W];
      grantData  = req_data[grantIdx*DATA_W +: DATA_W];
      commitNext = grantValid && (grantAddr != '0);
   end
   // Register the granted write; writes to x0 load the data path but never assert RegWrite
   always_ff @(posedge clk) begin
      if (reset) begin
         RegWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (grantValid) begin
         RegWrite  <= commitNext;
         writeReg  <= grantAddr;
         writeData <= grantData;
      end else
         RegWrite <= 1'b0;
   end
   // Count committed writes, holding at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (reset)
         commit_count <= '0;
      else if (commitNext && commit_count != '1)
         commit_count <= commit_count + 1'b1;
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector bench for regfile_wb_arbiter (follows WB_RR_EN like the DUT)
module tb_regfile_wb_arbiter;
   typedef struct {
      logic [2:0]  valid;
      logic [4:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  ready;
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [15:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  reqValid = '0;
   logic [4:0]  a0 = '0, a1 = '0, a2 = '0;
   logic [31:0] d0 = '0, d1 = '0, d2 = '0;
   logic [2:0]  reqReady, reqReady4;
   logic        regWrite, regWrite4;
   logic [4:0]  writeReg, writeReg4;
   logic [31:0] writeData, writeData4;
   logic [15:0] commitCount;
   logic [3:0]  commitCount4;
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[13];

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk(clk), .reset(reset), .req_valid(reqValid),
      .req_addr({a2, a1, a0}), .req_data({d2, d1, d0}),
      .req_ready(reqReady), .RegWrite(regWrite), .writeReg(writeReg),
      .writeData(writeData), .commit_count(commitCount)
   );

   regfile_wb_arbiter #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .req_valid(reqValid),
      .req_addr({a2, a1, a0}), .req_data({d2, d1, d0}),
      .req_ready(reqReady4), .RegWrite(regWrite4), .writeReg(writeReg4),
      .writeData(writeData4), .commit_count(commitCount4)
   );

   function automatic vec_t mk(logic [2:0] v, logic [4:0] x0, logic [4:0] x1, logic [4:0] x2,
                               logic [31:0] y0, logic [31:0] y1, logic [31:0] y2,
                               logic [2:0] rdy, logic rw, logic [4:0] wr, logic [31:0] wd, logic [15:0] cnt);
      vec_t t;
      t.valid = v; t.a0 = x0; t.a1 = x1; t.a2 = x2;
      t.d0 = y0; t.d1 = y1; t.d2 = y2;
      t.ready = rdy; t.rw = rw; t.wr = wr; t.wd = wd; t.cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t t);
      reqValid = t.valid; a0 = t.a0; a1 = t.a1; a2 = t.a2;
      d0 = t.d0; d1 = t.d1; d2 = t.d2;
   endtask

   initial begin
      logic [2:0] rrReady[6];
      logic [4:0] rrAddr[6];
      logic [31:0] rrData[6];
      vecs[0] = mk(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b1, 5'd7, 32'hDEADBEEF, 16'd1);
      vecs[1] = mk(3'b000, 5'd0, 5'd7, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0, 5'd7, 32'hDEADBEEF, 16'd1);
      vecs[2] = mk(3'b001, 5'd0, 5'd0, 5'd0, 32'h5, 32'h0, 32'h0, 3'b001, 1'b0, 5'd0, 32'h5, 16'd1);
      vecs[3] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h5, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h5, 16'd1);
      vecs[4] = mk(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'hAA, 3'b100, 1'b1, 5'd9, 32'hAA, 16'd2);
`ifdef WB_RR_EN
      rrReady = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rrAddr  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
      rrData  = '{32'h11, 32'h22, 32'h33, 32'h11, 32'h22, 32'h33};
      vecs[12] = mk(3'b101, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33, 16'd10);
`else
      rrReady = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      rrAddr  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
      rrData  = '{32'h11, 32'h11, 32'h11, 32'h11, 32'h11, 32'h11};
      vecs[12] = mk(3'b101, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11, 16'd10);
`endif
      for (int i = 0; i < 6; i++)
         vecs[5+i] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                        rrReady[i], 1'b1, rrAddr[i], rrData[i], 16'(3 + i));
      vecs[11] = mk(3'b110, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22, 16'd9);

      reqValid = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", reqReady, 3'b000);
      chk("rst_regwrite", regWrite, 1'b0);
      chk("rst_writereg", writeReg, 5'd0);
      chk("rst_writedata", writeData, 32'h0);
      chk("rst_count", commitCount, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      reqValid = 3'b000;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_ready", i), reqReady, vecs[i].ready);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_regwrite", i), regWrite, vecs[i].rw);
         chk($sformatf("v%0d_writereg", i), writeReg, vecs[i].wr);
         chk($sformatf("v%0d_writedata", i), writeData, vecs[i].wd);
         chk($sformatf("v%0d_count", i), commitCount, vecs[i].cnt);
      end

      @(negedge clk);
      reset = 1'b1; reqValid = 3'b000;
      @(negedge clk);
      reset = 1'b0;
      reqValid = 3'b010; a1 = 5'd7; d1 = 32'h77;
      #1;
      chk("mid_ready_pre", reqReady, 3'b010);
      @(posedge clk);
      #1;
      chk("mid_regwrite_pre", regWrite, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      reqValid = 3'b111; a0 = 5'd1; a1 = 5'd2; a2 = 5'd3; d0 = 32'h11; d1 = 32'h22; d2 = 32'h33;
      #1;
      chk("mid_ready_in_reset", reqReady, 3'b000);
      @(posedge clk);
      #1;
      chk("mid_regwrite_cancel", regWrite, 1'b0);
      chk("mid_count_clear", commitCount, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_first_grant", reqReady, 3'b001);
      @(posedge clk);
      #1;
      chk("mid_first_writereg", writeReg, 5'd1);
      chk("mid_first_count", commitCount, 16'd1);
      @(negedge clk);
      #1;
`ifdef WB_RR_EN
      chk("mid_second_grant", reqReady, 3'b010);
`else
      chk("mid_second_grant", reqReady, 3'b001);
`endif

      reset = 1'b1; reqValid = 3'b000;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         reqValid = 3'b001; a0 = 5'd5; d0 = 32'(i);
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d_count4", i), commitCount4, (i + 1 > 15) ? 15 : i + 1);
         chk($sformatf("sat%0d_count16", i), commitCount, i + 1);
      end
      @(negedge clk);
      reqValid = 3'b000;
      @(posedge clk);
      #1;
      chk("sat_idle_regwrite", regWrite4, 1'b0);
      chk("sat_hold_count4", commitCount4, 4'd15);
      chk("sat_hold_writedata", writeData4, 32'd19);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
